// File: rtl/multicycle_controller_hs.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_hs
// Purpose  : RV32I multicycle main controller with memory ready handshake,
//            illegal-opcode trap, wait timeout and retired-instruction count.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller_hs #(
  parameter int CNT_W           = 32,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int MAX_WAIT        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             PCUpdate,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             Branch,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instret
);

  localparam logic [4:0] S_FETCH   = 5'd0;
  localparam logic [4:0] S_DECODE  = 5'd1;
  localparam logic [4:0] S_EXEC_R  = 5'd2;
  localparam logic [4:0] S_EXEC_I  = 5'd3;
  localparam logic [4:0] S_ALU_WB  = 5'd4;
  localparam logic [4:0] S_MEM_ADR = 5'd5;
  localparam logic [4:0] S_MEM_RD  = 5'd6;
  localparam logic [4:0] S_MEM_WB  = 5'd7;
  localparam logic [4:0] S_MEM_WR  = 5'd8;
  localparam logic [4:0] S_BRANCH  = 5'd9;
  localparam logic [4:0] S_JAL     = 5'd10;
  localparam logic [4:0] S_JALR    = 5'd11;
  localparam logic [4:0] S_JUMP    = 5'd12;
  localparam logic [4:0] S_JUMP_R  = 5'd13;
  localparam logic [4:0] S_PCJ     = 5'd14;
  localparam logic [4:0] S_LUI     = 5'd15;
  localparam logic [4:0] S_TRAP    = 5'd16;

  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_BR   = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_JALR = 7'b1100111;
  localparam logic [6:0] c_OP_LUI  = 7'b0110111;

  localparam int              c_WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LIM = c_WAIT_W'(MAX_WAIT);

  logic [4:0]          state_q, state_d;
  logic [c_WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]    instret_q;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;

  logic                w_in_wait;
  logic [c_WAIT_W-1:0] w_wait_inc;
  logic                w_wait_exp;
  logic                w_timeout;
  logic                w_bad_op;
  logic                w_retire;

  assign w_in_wait  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // The limit is hit on the stalled cycle that would bring the count to MAX_WAIT.
  assign w_wait_inc = wait_q + c_WAIT_W'(1);
  assign w_wait_exp = (MAX_WAIT > 0) && (w_wait_inc == c_WAIT_LIM);

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      if (w_retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    w_timeout = 1'b0;
    w_bad_op  = 1'b0;
    w_retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (w_wait_exp) begin
          state_d   = S_TRAP;
          w_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          c_OP_R:           state_d = S_EXEC_R;
          c_OP_I:           state_d = S_EXEC_I;
          c_OP_LW, c_OP_SW: state_d = S_MEM_ADR;
          c_OP_BR:          state_d = S_BRANCH;
          c_OP_JAL:         state_d = S_JAL;
          c_OP_JALR:        state_d = S_JALR;
          c_OP_LUI:         state_d = S_LUI;
          default: begin
            w_bad_op = 1'b1;
            state_d  = (HALT_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_ALU_WB: begin
        state_d  = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEM_ADR: state_d = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (w_wait_exp) begin
          state_d   = S_TRAP;
          w_timeout = 1'b1;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          w_retire = 1'b1;
        end else if (w_wait_exp) begin
          state_d   = S_TRAP;
          w_timeout = 1'b1;
        end
      end
      S_MEM_WB, S_BRANCH, S_PCJ, S_LUI: begin
        state_d  = S_FETCH;
        w_retire = 1'b1;
      end
      S_JAL:    state_d = S_JUMP;
      S_JALR:   state_d = S_JUMP_R;
      S_JUMP:   state_d = S_PCJ;
      S_JUMP_R: state_d = S_ALU_WB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (w_in_wait && !mem_ready) begin
      wait_d = w_wait_inc;
    end
  end

  // Flags stay up only while parked in TRAP; otherwise they last one cycle.
  assign illegal_d = w_bad_op  | ((state_q == S_TRAP) & illegal_q);
  assign timeout_d = w_timeout | ((state_q == S_TRAP) & timeout_q);

  // Output decode; everything is forced low while rst is held.
  always_comb begin
    mem_req   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    PCUpdate  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    Branch    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    ImmSrc    = 3'b000;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCUpdate  = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = 3'b010;
        end
        S_EXEC_R: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXEC_I: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b11;
        end
        S_ALU_WB, S_MEM_WB: begin
          RegWrite  = 1'b1;
          ResultSrc = (state_q == S_MEM_WB) ? 2'b01 : 2'b00;
        end
        S_MEM_ADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (opcode == c_OP_SW) ? 3'b001 : 3'b000;
        end
        S_MEM_RD, S_MEM_WR: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = (state_q == S_MEM_WR);
        end
        S_BRANCH: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b01;
          Branch  = 1'b1;
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        S_JALR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_JUMP: begin
          ImmSrc   = 3'b011;
          ALUSrcA  = 2'b01;
          ALUSrcB  = 2'b01;
          RegWrite = 1'b1;
        end
        S_JUMP_R: begin
          ALUSrcA  = 2'b01;
          ALUSrcB  = 2'b10;
          PCUpdate = 1'b1;
        end
        S_PCJ: PCUpdate = 1'b1;
        S_LUI: begin
          ImmSrc    = 3'b100;
          ResultSrc = 2'b11;
          RegWrite  = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  assign illegal     = illegal_q & ~rst;
  assign mem_timeout = timeout_q & ~rst;
  assign instret     = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller_hs
// Purpose  : Directed self-checking bench for multicycle_controller_hs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller_hs;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: CNT_W=4, halt on illegal, no timeout
  logic        rst_a, rdy_a;
  logic [6:0]  op_a;
  logic        mr_a, rw_a, mw_a, pcu_a, irw_a, ads_a, br_a, ill_a, to_a;
  logic [1:0]  sa_a, sb_a, rs_a, aop_a;
  logic [2:0]  imm_a;
  logic [3:0]  instret_a;
  logic [17:0] ctl_a;

  // Instance B: CNT_W=32, pulse on illegal, MAX_WAIT=4
  logic        rst_b, rdy_b;
  logic [6:0]  op_b;
  logic        mr_b, rw_b, mw_b, pcu_b, irw_b, ads_b, br_b, ill_b, to_b;
  logic [1:0]  sa_b, sb_b, rs_b, aop_b;
  logic [2:0]  imm_b;
  logic [31:0] instret_b;
  logic [17:0] ctl_b;

  multicycle_controller_hs #(.CNT_W(4), .HALT_ON_ILLEGAL(1), .MAX_WAIT(0)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(op_a), .mem_ready(rdy_a),
    .mem_req(mr_a), .RegWrite(rw_a), .MemWrite(mw_a), .PCUpdate(pcu_a),
    .IRWrite(irw_a), .AdrSrc(ads_a), .Branch(br_a), .ALUSrcA(sa_a),
    .ALUSrcB(sb_a), .ResultSrc(rs_a), .ALUOp(aop_a), .ImmSrc(imm_a),
    .illegal(ill_a), .mem_timeout(to_a), .instret(instret_a)
  );

  multicycle_controller_hs #(.CNT_W(32), .HALT_ON_ILLEGAL(0), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(op_b), .mem_ready(rdy_b),
    .mem_req(mr_b), .RegWrite(rw_b), .MemWrite(mw_b), .PCUpdate(pcu_b),
    .IRWrite(irw_b), .AdrSrc(ads_b), .Branch(br_b), .ALUSrcA(sa_b),
    .ALUSrcB(sb_b), .ResultSrc(rs_b), .ALUOp(aop_b), .ImmSrc(imm_b),
    .illegal(ill_b), .mem_timeout(to_b), .instret(instret_b)
  );

  assign ctl_a = {mr_a, rw_a, mw_a, pcu_a, irw_a, ads_a, br_a, sa_a, sb_a, rs_a, aop_a, imm_a};
  assign ctl_b = {mr_b, rw_b, mw_b, pcu_b, irw_b, ads_b, br_b, sa_b, sb_b, rs_b, aop_b, imm_b};

  function automatic logic [17:0] ctl(input logic mr, rw, mw, pcu, irw, ads, br,
                                      input logic [1:0] a, b, rs, op, input logic [2:0] imm);
    return {mr, rw, mw, pcu, irw, ads, br, a, b, rs, op, imm};
  endfunction

  logic [17:0] F1, F0, DEC, EXR, EXI, WB, MADR_L, MADR_S, MRD, MWB, MWR;
  logic [17:0] BRC, JALS, JUMP, PCJ, JALRS, JUMPR, LUIS;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // From FETCH with ready high: check FETCH and DECODE, leave in the exec state.
  task automatic run_fd(input logic [6:0] op, input string tag);
    op_a  = op;
    rdy_a = 1'b1;
    #1; chk({tag, "_fetch"}, ctl_a, F1);
    tick();
    #1; chk({tag, "_decode"}, ctl_a, DEC);
    tick();
  endtask

  initial begin
    F1     = ctl(1,0,0,1,1,0,0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000);
    F0     = ctl(1,0,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000);
    DEC    = ctl(0,0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b010);
    EXR    = ctl(0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 2'b10, 3'b000);
    EXI    = ctl(0,0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b11, 3'b000);
    WB     = ctl(0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    MADR_L = ctl(0,0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000);
    MADR_S = ctl(0,0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b001);
    MRD    = ctl(1,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    MWB    = ctl(0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000);
    MWR    = ctl(1,0,1,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    BRC    = ctl(0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 2'b01, 3'b000);
    JALS   = ctl(0,0,0,0,0,0,0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000);
    JUMP   = ctl(0,1,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 2'b00, 3'b011);
    PCJ    = ctl(0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    JALRS  = ctl(0,0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000);
    JUMPR  = ctl(0,0,0,1,0,0,0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000);
    LUIS   = ctl(0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b11, 2'b00, 3'b100);

    rst_a = 1'b1; rdy_a = 1'b1; op_a = OP_ADD;
    rst_b = 1'b1; rdy_b = 1'b1; op_b = OP_ADD;
    tick(); tick();
    #1;
    chk("rst_ctl", ctl_a, 18'd0);
    chk("rst_instret", instret_a, 0);
    chk("rst_flags", {ill_a, to_a}, 0);

    // ADD, ready always high
    rst_a = 1'b0;
    run_fd(OP_ADD, "add");
    #1; chk("add_exec_r", ctl_a, EXR); tick();
    #1; chk("add_wb", ctl_a, WB); chk("add_instret_pre", instret_a, 0); tick();
    rdy_a = 1'b0;
    #1; chk("add_instret", instret_a, 1); chk("fetch_stall", ctl_a, F0);
    tick();

    // LW, three stalled cycles in MEM_RD
    run_fd(OP_LW, "lw");
    #1; chk("lw_madr", ctl_a, MADR_L); tick();
    for (int i = 0; i < 4; i++) begin
      rdy_a = (i == 3);
      #1; chk("lw_memrd", ctl_a, MRD);
      tick();
    end
    #1; chk("lw_memwb", ctl_a, MWB); tick();
    rdy_a = 1'b1;
    #1; chk("lw_instret", instret_a, 2); chk("lw_back_fetch", ctl_a, F1);

    // SW, two stalled cycles in MEM_WR
    run_fd(OP_SW, "sw");
    #1; chk("sw_madr", ctl_a, MADR_S); tick();
    for (int i = 0; i < 3; i++) begin
      rdy_a = (i == 2);
      #1; chk("sw_memwr", ctl_a, MWR); chk("sw_instret_hold", instret_a, 2);
      tick();
    end
    rdy_a = 1'b1;
    #1; chk("sw_instret", instret_a, 3); chk("sw_back_fetch", ctl_a, F1);

    run_fd(OP_BEQ, "beq");
    #1; chk("beq_branch", ctl_a, BRC); tick();
    #1; chk("beq_instret", instret_a, 4);

    run_fd(OP_JAL, "jal");
    #1; chk("jal_jal", ctl_a, JALS); tick();
    #1; chk("jal_jump", ctl_a, JUMP); tick();
    #1; chk("jal_pcj", ctl_a, PCJ); chk("jal_instret_pre", instret_a, 4); tick();
    #1; chk("jal_instret", instret_a, 5);

    run_fd(OP_JALR, "jalr");
    #1; chk("jalr_jalr", ctl_a, JALRS); tick();
    #1; chk("jalr_jump_r", ctl_a, JUMPR); tick();
    #1; chk("jalr_wb", ctl_a, WB); tick();
    #1; chk("jalr_instret", instret_a, 6);

    run_fd(OP_ADDI, "addi");
    #1; chk("addi_exec_i", ctl_a, EXI); tick();
    #1; chk("addi_wb", ctl_a, WB); tick();
    #1; chk("addi_instret", instret_a, 7);

    // Reset in the middle of a store
    run_fd(OP_SW, "swrst");
    #1; chk("swrst_madr", ctl_a, MADR_S); tick();
    rdy_a = 1'b0;
    #1; chk("swrst_memwr", ctl_a, MWR); tick();
    rst_a = 1'b1;
    #1; chk("swrst_in_rst", ctl_a, 18'd0); tick();
    rst_a = 1'b0;
    #1; chk("swrst_after", ctl_a, F0); chk("swrst_instret", instret_a, 0);

    // 16 LUIs wrap the 4-bit counter
    for (int k = 0; k < 16; k++) begin
      op_a = OP_LUI; rdy_a = 1'b1;
      tick(); tick();
      #1; chk("lui_ctl", ctl_a, LUIS); chk("lui_cnt", instret_a, k);
      tick();
    end
    #1; chk("lui_wrap", instret_a, 0);

    // Illegal opcode halts in TRAP
    op_a = OP_BAD; rdy_a = 1'b1;
    tick(); tick();
    #1; chk("ill_flag", ill_a, 1); chk("ill_ctl", ctl_a, 18'd0); chk("ill_instret", instret_a, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1; chk("ill_hold", {ill_a, ctl_a}, {1'b1, 18'd0});
    end
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    #1; chk("ill_cleared", ill_a, 0); chk("ill_rst_fetch", ctl_a, F1);

    // Instance B: illegal pulse then resume FETCH
    rst_b = 1'b0; op_b = OP_BAD; rdy_b = 1'b1;
    #1; chk("b_fetch", ctl_b, F1);
    tick(); tick();
    rdy_b = 1'b0;
    #1; chk("b_ill_pulse", ill_b, 1); chk("b_ill_fetch", ctl_b, F0); chk("b_ill_instret", instret_b, 0);
    tick();
    #1; chk("b_ill_drop", ill_b, 0);
    rst_b = 1'b1; tick(); rst_b = 1'b0;

    // Ready arrives on the 4th waiting cycle: no timeout
    op_b = OP_ADD;
    for (int i = 0; i < 4; i++) begin
      rdy_b = (i == 3);
      #1; chk("b_wait", ctl_b, (i == 3) ? F1 : F0);
      tick();
    end
    #1; chk("b_decode", ctl_b, DEC); chk("b_no_timeout", to_b, 0);
    tick(); tick(); tick();
    #1; chk("b_instret", instret_b, 1);

    // Ready stuck low: TRAP after 4 stalled cycles
    for (int i = 0; i < 4; i++) begin
      rdy_b = 1'b0;
      #1; chk("b_stall", ctl_b, F0); chk("b_stall_to", to_b, 0);
      tick();
    end
    #1; chk("b_timeout", to_b, 1); chk("b_trap_ctl", ctl_b, 18'd0); chk("b_trap_ill", ill_b, 0);
    rdy_b = 1'b1; tick();
    #1; chk("b_trap_hold", {to_b, ctl_b}, {1'b1, 18'd0});
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    #1; chk("b_timeout_clr", to_b, 0); chk("b_rst_fetch", ctl_b, F1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
